// File: rtl/audio_pkg.sv
// audio_pkg: shared widths and player state type for the audio record/playback path
package audio_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 20;
    localparam int SPD_W  = 3;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SEND, S_PAUSE} play_state_t;
endpackage

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: waits for a DAC LRCK fall, then shifts one sample out MSB first
module audio_dac_serializer
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lrck,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] sample,
    output logic              dat,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(DATA_W) + 1;
    logic          lrck_prev;
    logic [CW-1:0] bit_cnt;
    logic [DATA_W-1:0] shreg;
    assign done = busy && bit_cnt == CW'(DATA_W);
    // frame start on LRCK fall while armed, then one bit per bit clock; idles low once the word is out
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrck_prev <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            dat       <= 1'b0;
            shreg     <= '0;
        end else begin
            lrck_prev <= lrck;
            if (clear || done) begin
                busy    <= 1'b0;
                bit_cnt <= '0;
                dat     <= 1'b0;
            end else if (busy) begin
                dat     <= shreg[DATA_W-1];
                shreg   <= {shreg[DATA_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end else if (load && lrck_prev && !lrck) begin
                dat     <= sample[DATA_W-1];
                shreg   <= {sample[DATA_W-2:0], 1'b0};
                bit_cnt <= CW'(1);
                busy    <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/audio_player.sv
// audio_player: plays recorded SRAM samples to the WM8731 DAC with pause/stop and 1x..8x speed
module audio_player
    import audio_pkg::*;
(
    input  logic              aud_bclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    input  logic              fast,
    input  logic [SPD_W-1:0]  speed,
    input  logic [ADDR_W-1:0] last_rec,
    input  logic              aud_daclrck,
    output logic              aud_dacdat,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dq,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n,
    output logic              playing,
    output logic              done
);
    play_state_t       state;
    logic [DATA_W-1:0] sample;
    logic [SPD_W-1:0]  spd_r, rep_cnt;
    logic              fast_r, pause_pending, ser_busy, ser_done, repeat_smp;
    logic [ADDR_W:0]   step, next_addr;
    assign sram_we_n = 1'b1;
    assign {sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n} = '0;
    assign repeat_smp = !fast_r && spd_r != '0 && rep_cnt < spd_r;
    assign step = fast_r ? (ADDR_W+1)'(spd_r) + (ADDR_W+1)'(1) : (ADDR_W+1)'(1);
    assign next_addr = {1'b0, sram_addr} + step;
    audio_dac_serializer u_ser (
        .clk    (aud_bclk),
        .rst_n  (rst_n),
        .lrck   (aud_daclrck),
        .load   (state == S_WAIT),
        .clear  (stop),
        .sample (sample),
        .dat    (aud_dacdat),
        .busy   (ser_busy),
        .done   (ser_done)
    );
    // sequencer: fetch, wait for frame, decide repeat/advance/pause/end at each sample boundary
    always_ff @(negedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            sram_addr     <= '0;
            playing       <= 1'b0;
            done          <= 1'b0;
            sample        <= '0;
            spd_r         <= '0;
            fast_r        <= 1'b0;
            rep_cnt       <= '0;
            pause_pending <= 1'b0;
        end else begin
            done <= 1'b0;
            if (pause && state inside {S_FETCH, S_WAIT, S_SEND})
                pause_pending <= 1'b1;
            if (stop) begin
                state         <= S_IDLE;
                sram_addr     <= '0;
                rep_cnt       <= '0;
                playing       <= 1'b0;
                pause_pending <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        pause_pending <= 1'b0;
                        rep_cnt       <= '0;
                        sram_addr     <= '0;
                        if (start && last_rec != '0) begin
                            state   <= S_FETCH;
                            playing <= 1'b1;
                        end else if (start)
                            done <= 1'b1;
                    end
                    S_FETCH: begin
                        sample <= sram_dq;
                        fast_r <= fast;
                        spd_r  <= speed;
                        state  <= S_WAIT;
                    end
                    S_WAIT: if (ser_busy) state <= S_SEND;
                    S_SEND: if (ser_done) begin
                        if (repeat_smp) begin
                            rep_cnt <= rep_cnt + 1'b1;
                            state   <= S_WAIT;
                        end else begin
                            rep_cnt <= '0;
                            if (next_addr >= {1'b0, last_rec}) begin
                                state     <= S_IDLE;
                                sram_addr <= '0;
                                done      <= 1'b1;
                                playing   <= 1'b0;
                            end else begin
                                sram_addr <= next_addr[ADDR_W-1:0];
                                if (pause_pending) begin
                                    pause_pending <= 1'b0;
                                    state         <= S_PAUSE;
                                    playing       <= 1'b0;
                                end else
                                    state <= S_FETCH;
                            end
                        end
                    end
                    S_PAUSE: if (start) begin
                        state   <= S_FETCH;
                        playing <= 1'b1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_player.sv
// tb_audio_player: directed playback scenarios checked against a frame-level behavioural model
module tb_audio_player;
    logic        aud_bclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, fast = 1'b0;
    logic [2:0]  speed = '0;
    logic [19:0] last_rec = '0;
    logic        aud_daclrck = 1'b1;
    logic        aud_dacdat;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq;
    logic        sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic        playing, done;
    logic [15:0] mem [16];
    int checks = 0, errors = 0;
    int done_cnt = 0;
    logic [15:0] got [$];
    bit chk_en = 1'b0;

    assign sram_dq = mem[sram_addr[3:0]];

    audio_player dut (
        .aud_bclk(aud_bclk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .fast(fast), .speed(speed), .last_rec(last_rec), .aud_daclrck(aud_daclrck),
        .aud_dacdat(aud_dacdat), .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .playing(playing), .done(done)
    );

    initial forever #5 aud_bclk = ~aud_bclk;
    initial forever begin
        repeat (16) @(posedge aud_bclk);
        #2 aud_daclrck = ~aud_daclrck;
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: the playback is a list of (address, is-repeat) frames; each frame goes out
    // on an LRCK fall once the player is ready, and the list ends with a done pulse
    typedef struct {int addr; bit rep;} ent_t;
    ent_t q [$];
    int   cyc = 0, arm = 0, mbit = 0, mmode = 0;
    bit   mlp = 0, mpend = 0, fall = 0, oldpend = 0;
    logic [15:0] mcur = '0;
    logic exp_dat = 0, exp_play = 0, exp_done = 0;
    logic [19:0] exp_addr = '0;

    task automatic build();
        q.delete();
        if (fast && speed != 0)
            for (int a = 0; a < int'(last_rec); a += int'(speed) + 1) q.push_back('{addr: a, rep: 1'b0});
        else
            for (int a = 0; a < int'(last_rec); a++)
                for (int r = 0; r <= int'(speed); r++) q.push_back('{addr: a, rep: (r > 0)});
    endtask

    initial forever begin
        @(negedge aud_bclk or negedge rst_n);
        if (!rst_n) begin
            mmode = 0; q.delete(); mlp = 0; mpend = 0; mbit = 0; cyc = 0;
            exp_dat = 0; exp_play = 0; exp_done = 0; exp_addr = '0;
        end else begin
            fall = mlp && !aud_daclrck;
            mlp = aud_daclrck;
            cyc++;
            exp_done = 0;
            oldpend = mpend;
            if ((mmode == 1 || mmode == 2) && pause) mpend = 1;
            if (stop) begin
                mmode = 0; q.delete(); mpend = 0;
                exp_dat = 0; exp_play = 0; exp_addr = '0;
            end else if (mmode == 0) begin
                mpend = 0;
                if (start && last_rec == 0) exp_done = 1;
                else if (start) begin
                    build(); mmode = 1; arm = cyc + 2; exp_play = 1; exp_addr = '0;
                end
            end else if (mmode == 3) begin
                if (start) begin mmode = 1; arm = cyc + 2; exp_play = 1; end
            end else if (mmode == 1) begin
                if (cyc >= arm && fall) begin
                    mcur = mem[q[0].addr]; q.pop_front();
                    exp_dat = mcur[15]; mbit = 1; mmode = 2;
                end
            end else if (mbit < 16) begin
                exp_dat = mcur[15-mbit]; mbit++;
            end else begin
                exp_dat = 0;
                if (q.size() == 0) begin
                    mmode = 0; exp_done = 1; exp_play = 0; exp_addr = '0;
                end else begin
                    exp_addr = 20'(q[0].addr);
                    if (q[0].rep) begin mmode = 1; arm = cyc + 1; end
                    else if (oldpend) begin mmode = 3; mpend = 0; exp_play = 0; end
                    else begin mmode = 1; arm = cyc + 2; end
                end
            end
        end
    end

    // per-cycle comparison against the model, sampled half a period after the update edge
    initial forever begin
        @(posedge aud_bclk);
        if (chk_en) begin
            chk("dacdat", 32'(aud_dacdat), 32'(exp_dat));
            chk("playing", 32'(playing), 32'(exp_play));
            chk("done", 32'(done), 32'(exp_done));
            chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
            chk("strobes", 32'({sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'h10);
        end
    end

    initial forever begin
        @(posedge aud_bclk);
        if (rst_n && done === 1'b1) done_cnt++;
    end

    // independent frame capture: 16 bits following each LRCK fall while playing
    int cap_n = 0;
    bit cap_prev = 1;
    logic [15:0] cap_w;
    initial forever begin
        @(posedge aud_bclk);
        if (cap_n > 0) begin
            cap_w = {cap_w[14:0], aud_dacdat};
            cap_n--;
            if (cap_n == 0) got.push_back(cap_w);
        end else if (cap_prev && !aud_daclrck && playing === 1'b1) begin
            cap_w = {15'b0, aud_dacdat};
            cap_n = 15;
        end
        cap_prev = aud_daclrck;
    end

    task automatic tick(); @(posedge aud_bclk); #1; endtask
    task automatic pulse_start(); @(negedge aud_daclrck); tick(); start = 1; tick(); start = 0; endtask
    task automatic wait_idle(input string nm);
        int i = 0;
        while (playing && i < 700) begin tick(); i++; end
        chk(nm, 32'(playing), 32'(0));
    endtask

    int gb, db;
    int fexp [4];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(16'h1357 * (i + 1));
        repeat (3) tick();
        chk("rst_dacdat", 32'(aud_dacdat), 0);
        chk("rst_addr", 32'(sram_addr), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_strobes", 32'({sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n}), 32'h10);
        chk_en = 1;
        rst_n = 1;
        tick();
        // normal 1x playback of three words
        mem[0] = 16'hA5C3; mem[1] = 16'h0001; mem[2] = 16'h8000;
        last_rec = 3; speed = 0; fast = 0;
        gb = got.size(); db = done_cnt;
        pulse_start();
        wait_idle("normal_end");
        chk("normal_frames", 32'(got.size() - gb), 3);
        chk("normal_f0", 32'(got[gb]), 32'hA5C3);
        chk("normal_f1", 32'(got[gb+1]), 32'h0001);
        chk("normal_f2", 32'(got[gb+2]), 32'h8000);
        chk("normal_done", 32'(done_cnt - db), 1);
        for (int i = 0; i < 16; i++) mem[i] = 16'(16'h1357 * (i + 1));
        // fast 3x: addresses 0,3,6,9
        last_rec = 10; speed = 2; fast = 1;
        gb = got.size(); db = done_cnt;
        pulse_start();
        wait_idle("fast_end");
        fexp = '{0, 3, 6, 9};
        chk("fast_frames", 32'(got.size() - gb), 4);
        for (int i = 0; i < 4; i++) chk("fast_word", 32'(got[gb+i]), 32'(mem[fexp[i]]));
        chk("fast_done", 32'(done_cnt - db), 1);
        // slow 2x: addresses 0,0,1,1
        last_rec = 2; speed = 1; fast = 0;
        gb = got.size(); db = done_cnt;
        pulse_start();
        wait_idle("slow_end");
        fexp = '{0, 0, 1, 1};
        chk("slow_frames", 32'(got.size() - gb), 4);
        for (int i = 0; i < 4; i++) chk("slow_word", 32'(got[gb+i]), 32'(mem[fexp[i]]));
        chk("slow_done", 32'(done_cnt - db), 1);
        // pause during frame 4, hold three LRCK periods, resume at 5
        last_rec = 10; speed = 0; fast = 0;
        gb = got.size(); db = done_cnt;
        pulse_start();
        for (int i = 0; i < 700 && sram_addr != 20'd4; i++) tick();
        chk("pause_reach4", 32'(sram_addr), 4);
        @(negedge aud_daclrck);
        repeat (5) tick();
        pause = 1; tick(); pause = 0;
        wait_idle("pause_enter");
        repeat (96) tick();
        chk("pause_addr", 32'(sram_addr), 5);
        chk("pause_dacdat", 32'(aud_dacdat), 0);
        chk("pause_nodone", 32'(done_cnt - db), 0);
        chk("pause_frames", 32'(got.size() - gb), 5);
        pulse_start();
        wait_idle("resume_end");
        chk("resume_frames", 32'(got.size() - gb), 10);
        chk("resume_f4", 32'(got[gb+4]), 32'(mem[4]));
        chk("resume_f5", 32'(got[gb+5]), 32'(mem[5]));
        chk("resume_f9", 32'(got[gb+9]), 32'(mem[9]));
        chk("resume_done", 32'(done_cnt - db), 1);
        // stop at bit 7 of the first frame
        db = done_cnt;
        pulse_start();
        @(negedge aud_daclrck);
        repeat (8) tick();
        stop = 1; tick(); stop = 0;
        chk("stop_dacdat", 32'(aud_dacdat), 0);
        chk("stop_addr", 32'(sram_addr), 0);
        chk("stop_playing", 32'(playing), 0);
        repeat (40) tick();
        chk("stop_nodone", 32'(done_cnt - db), 0);
        // asynchronous reset in the middle of a frame
        pulse_start();
        @(negedge aud_daclrck);
        repeat (4) tick();
        #2;
        chk("arst_pre_playing", 32'(playing), 1);
        rst_n = 0;
        #1;
        chk("arst_playing", 32'(playing), 0);
        chk("arst_dacdat", 32'(aud_dacdat), 0);
        chk("arst_addr", 32'(sram_addr), 0);
        chk("arst_done", 32'(done), 0);
        repeat (3) tick();
        rst_n = 1;
        repeat (3) tick();
        // empty recording
        last_rec = 0;
        db = done_cnt;
        pulse_start();
        repeat (3) tick();
        chk("empty_done", 32'(done_cnt - db), 1);
        chk("empty_playing", 32'(playing), 0);
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_player.md
Name: audio_player

Overview:
- Playback counterpart of the audio recorder: reads 16-bit mono samples from external SRAM at addresses 0..last_rec-1 and serialises each one MSB-first onto the WM8731 DAC data line.
- Sits downstream of the recorder; consumes its SRAM contents and its last_rec length output.
- Supports pause/resume, stop, fast playback (address skip) and slow playback (zero-order hold, sample repeat), with speed 1x..8x.

Parameters:
DATA_W, 16, sample width, serialised MSB first
ADDR_W, 20, SRAM word address width
SPD_W, 3, speed field width; playback factor = speed+1 (1..8)

Ports:
aud_bclk  in  1  codec bit clock; all state updates on negedge aud_bclk
rst_n  in  1  reset, asynchronous, active-low
start  in  1  level; begin from IDLE, or resume from PAUSE
pause  in  1  level; request pause at next sample boundary
stop  in  1  level; abort to IDLE
fast  in  1  1 = fast mode, 0 = slow mode (ignored when speed=0)
speed  in  SPD_W  playback factor minus one
last_rec  in  ADDR_W  recorded length in samples, from the recorder
aud_daclrck  in  1  codec DAC LR clock
aud_dacdat  out  1  serial DAC data
sram_addr  out  ADDR_W  read address
sram_dq  in  DATA_W  SRAM read data
sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes
playing  out  1  high in FETCH/WAIT/SEND
done  out  1  one-cycle pulse on natural end of playback

Behaviour:
- Reset (async, rst_n=0): state IDLE, sram_addr=0, aud_dacdat=0, playing=0, done=0, sample/counters/pause_pending/lrck_prev=0. The SRAM strobes are static: we_n=1, ce_n=oe_n=ub_n=lb_n=0 at all times, including reset.
- States: IDLE, FETCH, WAIT, SEND, PAUSE.
- IDLE:
  - start=1 with last_rec!=0 -> FETCH, sram_addr=0, rep_cnt=0.
  - start=1 with last_rec==0 -> stay IDLE, done pulses.
- FETCH: one cycle. Register sample<=sram_dq; the address has been stable at least 1 cycle. Latch fast/speed into spd_r. -> WAIT.
- WAIT: lrck_prev tracks aud_daclrck every cycle. On the cycle with lrck_prev=1 and aud_daclrck=0:
  - aud_dacdat<=sample[15], bit_cnt<=1 -> SEND.
- SEND: each cycle aud_dacdat<=sample[15-bit_cnt], bit_cnt++. When bit_cnt==16 (i.e. 16 bits already driven), aud_dacdat<=0 and the boundary logic runs:
  - Slow mode, spd_r>0, rep_cnt<spd_r: rep_cnt++, same address -> WAIT (no refetch).
  - Otherwise step = fast ? spd_r+1 : 1; rep_cnt<=0; next = sram_addr+step, computed at ADDR_W+1 bits.
  - next >= last_rec (including carry-out): -> IDLE, done=1, sram_addr<=0.
  - Else, pause_pending=1: sram_addr<=next, clear pause_pending -> PAUSE.
  - Else: sram_addr<=next -> FETCH.
- pause_pending is set by pause=1 in FETCH/WAIT/SEND; it is cleared in IDLE.
- PAUSE: aud_dacdat=0.
  - start -> FETCH (resumes at held address).
  - stop -> IDLE.
  - pause is ignored.
- stop=1 in any non-IDLE state -> IDLE next edge. The current sample is truncated, aud_dacdat<=0, sram_addr<=0, no done pulse.
- Simultaneous inputs: stop has priority over pause and start; start has priority over pause in PAUSE.
- Speed/mode changes take effect only at the next FETCH.
- last_rec is sampled continuously; it must be held constant while playing.

Decomposition:
- Shared package audio_pkg: DATA_W/ADDR_W/SPD_W constants and a state enum type for the player states. The recorder is to adopt the package later.
- One sub-module, audio_dac_serializer: LRCK falling-edge detect plus the 16-bit MSB-first shift. Interface: load/sample in, busy/done out.
- The address/speed sequencer stays in audio_player.

Test Plan:
- Normal: SRAM[0..2]=16'hA5C3,16'h0001,16'h8000, last_rec=3, speed=0, start pulse -> three 16-bit frames A5C3,0001,8000 MSB-first, each starting on the negedge after the daclrck fall; done pulses once; state back to IDLE.
- Fast: fast=1, speed=2, last_rec=10 -> addresses read 0,3,6,9, then done (next=12>=10).
- Slow: fast=0, speed=1, last_rec=2 -> frames from addr 0,0,1,1, then done.
- Pause/resume: pause asserted mid-frame at addr 4 -> frame 4 completes, sram_addr=5, dacdat=0 held across 3 LRCK periods; start -> playback resumes at addr 5.
- Stop/reset: stop at bit 7 of a frame -> dacdat=0 and sram_addr=0 next edge, no done pulse. rst_n low mid-SEND -> all outputs return to reset values immediately, without waiting for a clock edge.
- Edge case last_rec=0: start -> done pulse, state remains IDLE.
